// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared encodings for the hazard controller: FSM states and PC mux select values.
package pipeline_hazard_controller_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'b00,
    ST_MUL_WAIT  = 2'b01,
    ST_MUL_ISSUE = 2'b10
  } state_e;

  typedef enum logic {
    PC_PLUS4  = 1'b0,
    PC_BRANCH = 1'b1
  } pc_src_e;

  localparam int CNT_W = 4;

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Pipeline-side bundle for the hazard controller: ID/EX hazard fields in, stall/flush controls out.
interface pipeline_hazard_controller_if;

  logic [4:0] ID_Rs;
  logic [4:0] ID_Rt;
  logic       ID_UsesRt;
  logic       ID_MulStart;
  logic       EX_MemRead;
  logic [4:0] EX_RtDest;
  logic       EX_BranchTaken;

  logic       PCWrite;
  logic       IFIDWrite;
  logic       IDEXBubble;
  logic       IFIDFlush;
  logic       PCSrcSel;
  logic       MulBusy;
  logic [1:0] State;

  modport master (
    output ID_Rs, ID_Rt, ID_UsesRt, ID_MulStart, EX_MemRead, EX_RtDest, EX_BranchTaken,
    input  PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, PCSrcSel, MulBusy, State
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_UsesRt, ID_MulStart, EX_MemRead, EX_RtDest, EX_BranchTaken,
    output PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, PCSrcSel, MulBusy, State
  );

endinterface

// File: rtl/pipeline_hazard_controller_load_use_detect.sv
// Combinational load-use detector: flags an ID instruction reading the register an EX load writes.
module load_use_detect (
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt_dest,
  output logic       lu
);

  logic rs_hit;
  logic rt_hit;

  // $0 is hardwired to zero, so a load targeting it can never create a dependency.
  assign rs_hit = (ex_rt_dest == id_rs);
  assign rt_hit = id_uses_rt && (ex_rt_dest == id_rt);
  assign lu     = ex_mem_read && (ex_rt_dest != 5'd0) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Hazard sequencer: load-use stalls, branch flushes and a fixed-length multiply hold in ID.
// Outputs are combinational from the current state and the ID/EX fields.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int MUL_CYCLES = 4
) (
  input  logic                          Clk,
  input  logic                          Reset,
  pipeline_hazard_controller_if.slave   hz
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu;

  logic    pc_write;
  logic    ifid_write;
  logic    idex_bubble;
  logic    ifid_flush;
  pc_src_e pc_src;
  logic    mul_busy;

  load_use_detect u_load_use_detect (
    .id_rs       (hz.ID_Rs),
    .id_rt       (hz.ID_Rt),
    .id_uses_rt  (hz.ID_UsesRt),
    .ex_mem_read (hz.EX_MemRead),
    .ex_rt_dest  (hz.EX_RtDest),
    .lu          (lu)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    pc_src      = PC_PLUS4;
    mul_busy    = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (hz.EX_BranchTaken) begin
          pc_src     = PC_BRANCH;
          ifid_flush = 1'b1;
        end else if (lu) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
        end else if (hz.ID_MulStart) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          mul_busy    = 1'b1;
          cnt_d       = CNT_INIT;
          state_d     = (CNT_INIT == CNT_W'(0)) ? ST_MUL_ISSUE : ST_MUL_WAIT;
        end
      end

      ST_MUL_WAIT: begin
        // A taken branch here abandons the multiply; EX normally holds bubbles so it should not happen.
        if (hz.EX_BranchTaken) begin
          pc_src     = PC_BRANCH;
          ifid_flush = 1'b1;
          cnt_d      = '0;
          state_d    = ST_RUN;
        end else begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          mul_busy    = 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = ST_MUL_ISSUE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end

      ST_MUL_ISSUE: begin
        if (hz.EX_BranchTaken) begin
          pc_src     = PC_BRANCH;
          ifid_flush = 1'b1;
        end
        state_d = ST_RUN;
      end

      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase

    if (Reset) begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      idex_bubble = 1'b0;
      ifid_flush  = 1'b0;
      pc_src      = PC_PLUS4;
      mul_busy    = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hz.PCWrite    = pc_write;
  assign hz.IFIDWrite  = ifid_write;
  assign hz.IDEXBubble = idex_bubble;
  assign hz.IFIDFlush  = ifid_flush;
  assign hz.PCSrcSel   = pc_src;
  assign hz.MulBusy    = mul_busy;
  assign hz.State      = Reset ? ST_RUN : state_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: directed scenarios plus random traffic against a cycle-count model.
module tb_pipeline_hazard_controller;

  localparam int MUL_CYCLES = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_hazard_controller_if hz_if();

  pipeline_hazard_controller #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .Clk   (clk),
    .Reset (rst),
    .hz    (hz_if)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // Reference: how many MUL_WAIT-style stall cycles remain, and whether the issue cycle is next.
  int mdl_wait  = 0;
  bit mdl_issue = 1'b0;

  // Packed view {PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, PCSrcSel, MulBusy, State}
  function automatic logic [7:0] observe();
    return {hz_if.PCWrite, hz_if.IFIDWrite, hz_if.IDEXBubble, hz_if.IFIDFlush,
            hz_if.PCSrcSel, hz_if.MulBusy, hz_if.State};
  endfunction

  function automatic bit mdl_lu();
    return hz_if.EX_MemRead && (hz_if.EX_RtDest != 5'd0) &&
           ((hz_if.EX_RtDest == hz_if.ID_Rs) || (hz_if.ID_UsesRt && hz_if.EX_RtDest == hz_if.ID_Rt));
  endfunction

  function automatic logic [7:0] mdl_out();
    bit br;
    br = hz_if.EX_BranchTaken;
    if (rst)           return 8'b1100_0000;
    if (mdl_wait > 0)  return br ? 8'b1101_1001 : 8'b0010_0101;
    if (mdl_issue)     return br ? 8'b1101_1010 : 8'b1100_0010;
    if (br)            return 8'b1101_1000;
    if (mdl_lu())      return 8'b0010_0000;
    if (hz_if.ID_MulStart) return 8'b0010_0100;
    return 8'b1100_0000;
  endfunction

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                       input logic mul, input logic mem, input logic [4:0] dest, input logic br);
    hz_if.ID_Rs          = rs;
    hz_if.ID_Rt          = rt;
    hz_if.ID_UsesRt      = uses;
    hz_if.ID_MulStart    = mul;
    hz_if.EX_MemRead     = mem;
    hz_if.EX_RtDest      = dest;
    hz_if.EX_BranchTaken = br;
    @(negedge clk);
  endtask

  task automatic advance();
    bit br, lu, mul, r;
    br  = hz_if.EX_BranchTaken;
    lu  = mdl_lu();
    mul = hz_if.ID_MulStart;
    r   = rst;
    @(posedge clk);
    if (r) begin
      mdl_wait  = 0;
      mdl_issue = 1'b0;
    end else if (mdl_wait > 0) begin
      if (br)                 mdl_wait = 0;
      else if (mdl_wait == 1) begin mdl_wait = 0; mdl_issue = 1'b1; end
      else                    mdl_wait = mdl_wait - 1;
    end else if (mdl_issue) begin
      mdl_issue = 1'b0;
    end else if (!br && !lu && mul) begin
      mdl_wait = MUL_CYCLES - 1;
    end
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] obs;
    drive(5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0);
    obs = observe();
    n_checks++;
    if (obs !== 8'b1100_0000) begin
      n_fails++;
      $display("FAIL reset_outputs: got %b want %b", obs, 8'b1100_0000);
    end
    advance();
    rst = 1'b0;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    obs = observe();
    n_checks++;
    if (obs !== 8'b1100_0000) begin
      n_fails++;
      $display("FAIL reset_release: got %b want %b", obs, 8'b1100_0000);
    end
    advance();
  endtask

  task automatic test_load_use();
    logic [7:0] obs;
    drive(5'd5, 5'd9, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0);
    obs = observe();
    n_checks++;
    if (obs !== 8'b0010_0000 || obs !== mdl_out()) begin
      n_fails++;
      $display("FAIL lu_rs_stall: got %b want %b", obs, 8'b0010_0000);
    end
    advance();
    drive(5'd5, 5'd9, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    obs = observe();
    n_checks++;
    if (obs !== 8'b1100_0000) begin
      n_fails++;
      $display("FAIL lu_rs_release: got %b want %b", obs, 8'b1100_0000);
    end
    advance();
    drive(5'd3, 5'd12, 1'b1, 1'b0, 1'b1, 5'd12, 1'b0);
    obs = observe();
    n_checks++;
    if (obs !== 8'b0010_0000) begin
      n_fails++;
      $display("FAIL lu_rt_stall: got %b want %b", obs, 8'b0010_0000);
    end
    advance();
  endtask

  task automatic test_no_stall_cases();
    logic [7:0] obs;
    drive(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0);
    obs = observe();
    n_checks++;
    if (obs !== 8'b1100_0000) begin
      n_fails++;
      $display("FAIL lu_zero_reg: got %b want %b", obs, 8'b1100_0000);
    end
    advance();
    drive(5'd1, 5'd7, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0);
    obs = observe();
    n_checks++;
    if (obs !== 8'b1100_0000) begin
      n_fails++;
      $display("FAIL lu_unused_rt: got %b want %b", obs, 8'b1100_0000);
    end
    advance();
    drive(5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 5'd7, 1'b0);
    obs = observe();
    n_checks++;
    if (obs !== 8'b1100_0000) begin
      n_fails++;
      $display("FAIL lu_not_load: got %b want %b", obs, 8'b1100_0000);
    end
    advance();
  endtask

  task automatic test_multiply();
    logic [7:0] obs;
    logic [7:0] exp_seq [6];
    exp_seq = '{8'b0010_0100, 8'b0010_0101, 8'b0010_0101, 8'b0010_0101,
                8'b1100_0010, 8'b1100_0000};
    for (int i = 0; i < 6; i++) begin
      drive(5'd2, 5'd3, 1'b1, (i < 5) ? 1'b1 : 1'b0, 1'b0, 5'd0, 1'b0);
      obs = observe();
      n_checks++;
      if (obs !== exp_seq[i] || obs !== mdl_out()) begin
        n_fails++;
        $display("FAIL mul_seq cycle %0d: got %b want %b", i, obs, exp_seq[i]);
      end
      advance();
    end
  endtask

  task automatic test_branch_lu();
    logic [7:0] obs;
    drive(5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1);
    obs = observe();
    n_checks++;
    if (obs !== 8'b1101_1000) begin
      n_fails++;
      $display("FAIL branch_over_lu: got %b want %b", obs, 8'b1101_1000);
    end
    advance();
    drive(5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    obs = observe();
    n_checks++;
    if (obs !== 8'b1100_0000) begin
      n_fails++;
      $display("FAIL branch_one_cycle: got %b want %b", obs, 8'b1100_0000);
    end
    advance();
  endtask

  task automatic test_lu_mul();
    logic [7:0] obs;
    drive(5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0);
    obs = observe();
    n_checks++;
    if (obs !== 8'b0010_0000) begin
      n_fails++;
      $display("FAIL lu_mul_stall: got %b want %b", obs, 8'b0010_0000);
    end
    advance();
    drive(5'd8, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    obs = observe();
    n_checks++;
    if (obs !== 8'b0010_0100) begin
      n_fails++;
      $display("FAIL lu_mul_then_mul: got %b want %b", obs, 8'b0010_0100);
    end
    advance();
    drive(5'd8, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    obs = observe();
    n_checks++;
    if (obs !== 8'b0010_0101) begin
      n_fails++;
      $display("FAIL lu_mul_wait: got %b want %b", obs, 8'b0010_0101);
    end
    advance();
    // Drain the rest of the multiply under model control.
    for (int i = 0; i < MUL_CYCLES; i++) begin
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      obs = observe();
      n_checks++;
      if (obs !== mdl_out()) begin
        n_fails++;
        $display("FAIL lu_mul_drain %0d: got %b want %b", i, obs, mdl_out());
      end
      advance();
    end
  endtask

  task automatic test_reset_mid_mul();
    logic [7:0] obs;
    drive(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    advance();
    drive(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    obs = observe();
    n_checks++;
    if (obs !== 8'b0010_0101) begin
      n_fails++;
      $display("FAIL rst_mul_in_wait: got %b want %b", obs, 8'b0010_0101);
    end
    advance();
    rst = 1'b1;
    drive(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    obs = observe();
    n_checks++;
    if (obs !== 8'b1100_0000) begin
      n_fails++;
      $display("FAIL rst_mul_forced: got %b want %b", obs, 8'b1100_0000);
    end
    advance();
    rst = 1'b0;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    obs = observe();
    n_checks++;
    if (obs !== 8'b1100_0000) begin
      n_fails++;
      $display("FAIL rst_mul_after: got %b want %b", obs, 8'b1100_0000);
    end
    advance();
  endtask

  task automatic test_random();
    logic [7:0] obs, exp;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 9) == 0));
      exp = mdl_out();
      obs = observe();
      n_checks++;
      if (obs !== exp) begin
        n_fails++;
        $display("FAIL random cycle %0d: got %b want %b", i, obs, exp);
      end
      advance();
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_stall_cases();
    test_multiply();
    test_branch_lu();
    test_lu_mul();
    test_reset_mid_mul();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Sequencing controller for the 5-stage pipeline's hazard path: decides every cycle whether the PC and IF/ID registers advance, whether ID/EX takes a bubble, and whether IF/ID is flushed. It drives the select of the 32-bit 2:1 PC-source mux and the control-word bubble mux. It also holds a multicycle multiply in ID for a fixed number of cycles before releasing it to EX.

## Interface
Parameters
- MUL_CYCLES, 4, total cycles a multiply stalls in ID; legal range 2..15.

Ports
- Clk  in  1  pipeline clock, rising edge.
- Reset  in  1  synchronous, active-high.
- ID_Rs  in  5  rs field of the instruction in ID.
- ID_Rt  in  5  rt field of the instruction in ID.
- ID_UsesRt  in  1  the ID instruction reads rt.
- ID_MulStart  in  1  the ID instruction is a multicycle multiply.
- EX_MemRead  in  1  the EX instruction is a load.
- EX_RtDest  in  5  destination register of the EX load.
- EX_BranchTaken  in  1  branch/jump resolved taken in EX.
- PCWrite  out  1  1 = PC loads its next value.
- IFIDWrite  out  1  1 = IF/ID register loads.
- IDEXBubble  out  1  1 = ID/EX control word mux selects all-zero.
- IFIDFlush  out  1  1 = IF/ID instruction cleared to NOP.
- PCSrcSel  out  1  PC mux select: 0 = PC+4, 1 = branch target.
- MulBusy  out  1  multiply stall in progress.
- State  out  2  current FSM state, for debug.

## Operation
- States: RUN=2'b00, MUL_WAIT=2'b01, MUL_ISSUE=2'b10. 2'b11 is illegal and recovers to RUN on the next edge.
- 4-bit down-counter `cnt` is used only in MUL_WAIT.
- Load-use hazard (LU) = EX_MemRead & (EX_RtDest != 0) & ((EX_RtDest == ID_Rs) | (ID_UsesRt & EX_RtDest == ID_Rt)).
- Default outputs: PCWrite=1, IFIDWrite=1, IDEXBubble=0, IFIDFlush=0, PCSrcSel=0, MulBusy=0.
- RUN priority, highest first:
  - EX_BranchTaken: PCSrcSel=1, IFIDFlush=1. Stay in RUN. LU and ID_MulStart are ignored.
  - LU: PCWrite=0, IFIDWrite=0, IDEXBubble=1. Stay in RUN. ID_MulStart is ignored this cycle.
  - ID_MulStart: PCWrite=0, IFIDWrite=0, IDEXBubble=1, MulBusy=1. Load cnt=MUL_CYCLES-1 and go to MUL_WAIT.
- MUL_WAIT:
  - Outputs: PCWrite=0, IFIDWrite=0, IDEXBubble=1, MulBusy=1.
  - If cnt==1, go to MUL_ISSUE; otherwise decrement cnt.
  - EX_BranchTaken here takes the RUN branch behaviour and returns to RUN. This cannot occur in a legal pipeline (EX holds bubbles) but is defined.
- MUL_ISSUE:
  - Default outputs; the multiply advances to EX.
  - ID_MulStart and LU are ignored.
  - EX_BranchTaken gives flush behaviour.
  - Always goes to RUN.
- Outputs are combinational from state and inputs. State and cnt change only on the Clk rising edge.

## Timing
- Reset high at an edge: State=RUN and cnt=0 on that edge.
- While Reset=1, outputs are forced to PCWrite=1, IFIDWrite=1, all other outputs 0.
- Reset mid-multiply aborts the stall: RUN with default outputs from the reset cycle onward.
- Load-use: exactly 1 stall cycle, asserted in the same cycle LU is true; 0-cycle response latency.
- Multiply: stall asserted for exactly MUL_CYCLES consecutive cycles (trigger cycle plus MUL_CYCLES-1 in MUL_WAIT), then 1 MUL_ISSUE cycle with no stall.
- Branch flush: IFIDFlush and PCSrcSel are asserted in the same cycle as EX_BranchTaken, for 1 cycle; 1 wrong-path instruction is squashed.
- A load writing $0 never stalls.

## Structure
- Shared package/header holds the state encodings (RUN, MUL_WAIT, MUL_ISSUE) and the PCSrcSel encodings (PC_PLUS4=0, PC_BRANCH=1), used by the PC mux instance.
- One sub-module, `load_use_detect`: purely combinational, produces LU from the ID/EX fields.
- FSM, counter and output logic live in the top module.

## Test plan
- Load-use on rs: EX_MemRead=1, EX_RtDest=5, ID_Rs=5 -> that cycle PCWrite=0, IFIDWrite=0, IDEXBubble=1; next cycle (LU cleared) all default.
- Load-use on $0 and on an unused rt: EX_RtDest=0 with ID_Rs=0 -> no stall. EX_RtDest=7, ID_Rt=7, ID_UsesRt=0 -> no stall.
- Multiply with MUL_CYCLES=4, ID_MulStart held 1: stall for exactly 4 cycles with State sequence 00,01,01,01, then 1 cycle State=10 with no stall, then 00 with no retrigger.
- Branch plus LU in the same cycle: EX_BranchTaken=1 and LU true -> IFIDFlush=1, PCSrcSel=1, PCWrite=1, IDEXBubble=0.
- LU plus ID_MulStart in the same cycle -> 1 load stall and State stays 00; next cycle the multiply sequence begins.
- Reset asserted during MUL_WAIT (cnt=2) -> State=00 after the edge; outputs default while Reset is high.
